// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
// DIV_ZERO_CHK_EN is consumed by div_seq, not here.
package div_pkg;
    localparam int DIV_DW = 8;
    localparam int DIV_VW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// then subtract the divisor if it fits.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   r_in,
    input  logic [VW-1:0] divisor,
    input  logic          dbit,
    output logic [VW:0]   r_out,
    output logic          qbit
);
    logic [VW:0] r_shift;
    logic [VW:0] r_diff;
    // The top bit of R is dropped by the shift; it can only be set for a zero divisor.
    logic        unused_msb;

    assign unused_msb = r_in[VW];
    assign r_shift    = {r_in[VW-1:0], dbit};
    assign r_diff     = r_shift - {1'b0, divisor};
    assign qbit       = (r_shift >= {1'b0, divisor});
    assign r_out      = qbit ? r_diff : r_shift;
endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional DIV_ZERO_CHK_EN: short-circuit divide-by-zero to DONE and flag div_zero.
module div_seq
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);
    localparam int CW = $clog2(DW + 1);

    div_state_t    state_reg, state_next;
    logic [CW-1:0] count_reg;
    logic [DW-1:0] q_reg;
    logic [VW:0]   r_reg;
    logic [VW-1:0] d_reg;
    logic [VW:0]   r_step;
    logic          qbit;
    logic          accept;
    logic          last_step;

    assign accept    = (state_reg == IDLE) && in_valid;
    assign last_step = (count_reg == CW'(DW - 1));

    div_step #(.VW(VW)) u_step (
        .r_in    (r_reg),
        .divisor (d_reg),
        .dbit    (q_reg[DW-1]),
        .r_out   (r_step),
        .qbit    (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
`ifdef DIV_ZERO_CHK_EN
                    state_next = (divisor == '0) ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    // q_reg starts as the dividend and shifts quotient bits in from the LSB,
    // so after DW steps it holds the quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
        end else if (accept) begin
            count_reg <= '0;
            q_reg     <= dividend;
            r_reg     <= '0;
            d_reg     <= divisor;
`ifdef DIV_ZERO_CHK_EN
            if (divisor == '0) begin
                q_reg <= '1;
                r_reg <= {1'b0, dividend[VW-1:0]};
            end
`endif
        end else if (state_reg == CALC) begin
            count_reg <= count_reg + 1'b1;
            q_reg     <= {q_reg[DW-2:0], qbit};
            r_reg     <= r_step;
        end
    end

`ifdef DIV_ZERO_CHK_EN
    logic dz_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_reg <= 1'b0;
        end else if (accept) begin
            dz_reg <= (divisor == '0);
        end else if ((state_reg == DONE) && out_ready) begin
            dz_reg <= 1'b0;
        end
    end

    assign div_zero = dz_reg;
`else
    assign div_zero = 1'b0;
`endif

    assign quotient  = q_reg;
    assign remainder = r_reg[VW-1:0];
endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq (DW=8, VW=4), plus backpressure, mid-operation
// reset and an exhaustive operand sweep; honours DIV_ZERO_CHK_EN if defined.
module tb_div_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int n_pass  = 0;
    int n_total = 0;

`ifdef DIV_ZERO_CHK_EN
    localparam logic DZ_FLAG = 1'b1;
    localparam int   DZ_LAT  = 0;
`else
    localparam logic DZ_FLAG = 1'b0;
    localparam int   DZ_LAT  = 8;
`endif

    // lat = clock edges after the accepting edge until out_valid is seen.
    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[10];

    div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present operands, wait for acceptance, then wait for out_valid.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int lat);
        int waits = 0;
        while (!in_ready && waits < 50) begin
            step();
            waits++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic consume(input string name);
        check({name, "_busy_in_ready"}, int'(in_ready), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_out_valid_drop"}, int'(out_valid), 0);
        check({name, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        int         lat;
        logic [7:0] hq;
        logic [3:0] hr;

        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 8};
        vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 8};
        vecs[2] = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0, 8};
        vecs[3] = '{8'd0,   4'd1,  8'd0,   4'd0,  1'b0, 8};
        vecs[4] = '{8'hA5,  4'd0,  8'hFF,  4'd5,  DZ_FLAG, DZ_LAT};
        vecs[5] = '{8'd100, 4'd3,  8'd33,  4'd1,  1'b0, 8};
        vecs[6] = '{8'd13,  4'd13, 8'd1,   4'd0,  1'b0, 8};
        vecs[7] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 8};
        vecs[8] = '{8'd250, 4'd15, 8'd16,  4'd10, 1'b0, 8};
        vecs[9] = '{8'd0,   4'd0,  8'hFF,  4'd0,  DZ_FLAG, DZ_LAT};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) step();
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_quotient",  int'(quotient),  0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_div_zero",  int'(div_zero),  0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            $display("op %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d",
                     vecs[i].a, vecs[i].b, quotient, remainder, div_zero, lat);
            check($sformatf("v%0d_quotient", i),  int'(quotient),  int'(vecs[i].q));
            check($sformatf("v%0d_remainder", i), int'(remainder), int'(vecs[i].r));
            check($sformatf("v%0d_div_zero", i),  int'(div_zero),  int'(vecs[i].dz));
            check($sformatf("v%0d_latency", i),   lat,             vecs[i].lat);
            consume($sformatf("v%0d", i));
        end

        // Backpressure: result must hold still while out_ready stays low.
        run_op(8'd200, 4'd7, lat);
        hq = quotient;
        hr = remainder;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_quotient",  int'(quotient),  28);
            check("bp_remainder", int'(remainder), 4);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready",  int'(in_ready),  0);
        end
        $display("backpressure 200/7 held q=%0d r=%0d", hq, hr);
        consume("bp");

        // Asynchronous reset in the middle of a calculation.
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("calc_busy", int'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  int'(in_ready),  1);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_quotient",  int'(quotient),  0);
        check("arst_remainder", int'(remainder), 0);
        $display("async reset mid-CALC applied");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_op(8'd100, 4'd3, lat);
        $display("op 100/3 after reset -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        check("post_rst_quotient",  int'(quotient),  33);
        check("post_rst_remainder", int'(remainder), 1);
        check("post_rst_latency",   lat,             8);
        consume("post_rst");

        // Every operand pair, checked through the multiply identity.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic ok;
                run_op(8'(a), 4'(b), lat);
                if (b != 0) begin
                    ok = (int'(quotient) * b + int'(remainder) == a) &&
                         (int'(remainder) < b) && (div_zero == 1'b0) && (lat == 8);
                end else begin
                    ok = (quotient == 8'hFF) && (int'(remainder) == (a % 16)) &&
                         (div_zero == DZ_FLAG) && (lat == DZ_LAT);
                end
                n_total++;
                if (ok) begin
                    n_pass++;
                end else begin
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%0d lat=%0d, expected q*d+r==n, r<d",
                             a, b, quotient, remainder, div_zero, lat);
                end
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
            end
        end
        $display("sweep of 4096 operand pairs done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
